// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    // Access sequencer states
    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbIssue = 2'd1,
        ArbWait  = 2'd2,
        ArbDone  = 2'd3
    } arb_state_e;

    // Owner of the access currently in flight
    typedef enum logic {
        OwnIf = 1'b0,
        OwnDm = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-macro signals around the arbiter.
// slave: the arbiter's view; master: the core + memory environment view.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              flush;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr, flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
        output stall
    );

    modport master (
        output if_req, if_addr, flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
        input  stall
    );

endinterface

// File: rtl/arb_lat_counter.sv
// Memory latency down-counter: load MEM_LAT-1, count down, flag zero.
module arb_lat_counter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: load has priority, decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CntW'(MEM_LAT - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Count register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between instruction fetch and data ports.
// DM has priority; IF is forced after STARVE_MAX consecutive DM grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned StW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              drop_q, drop_d;
    logic [StW-1:0]    starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic grant_if, grant_dm, lat_zero, capture, starved;

    arb_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == ArbIssue),
        .dec_i  (state_q == ArbWait),
        .zero_o (lat_zero)
    );

    // Arbitration: only IDLE grants; flush blocks the IF grant for this cycle
    always_comb begin
        starved  = (starve_q == StW'(STARVE_MAX));
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state_q == ArbIdle) begin
            if (bus.if_req && !bus.flush && (!bus.dm_req || starved)) begin
                grant_if = 1'b1;
            end else if (bus.dm_req) begin
                grant_dm = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ArbIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> ISSUE -> WAIT (until latency elapses) -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ArbIdle:  if (grant_if || grant_dm) state_d = ArbIssue;
            ArbIssue: state_d = ArbWait;
            ArbWait:  if (lat_zero) state_d = ArbDone;
            ArbDone:  state_d = ArbIdle;
        endcase
    end

    // Output and datapath next values; every output leaves a flop
    always_comb begin
        capture     = (state_q == ArbWait) && lat_zero;
        owner_d     = owner_q;
        drop_d      = drop_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        if (grant_if) begin
            owner_d     = OwnIf;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
        end
        if (grant_dm) begin
            owner_d     = OwnDm;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.dm_we;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
            if (!starved) starve_d = starve_q + StW'(1);
        end
        if (!bus.if_req) starve_d = '0;

        // A killed fetch still drains the memory but never reaches the core
        if (capture) begin
            if (owner_q == OwnIf) begin
                if (!(drop_q || bus.flush)) begin
                    if_ready_d = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                end
            end else begin
                dm_ready_d = 1'b1;
                if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
            end
        end

        if ((owner_q == OwnIf) && bus.flush &&
            ((state_q == ArbIssue) || (state_q == ArbWait))) begin
            drop_d = 1'b1;
        end
        if (state_q == ArbDone) drop_d = 1'b0;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q     <= OwnIf;
            drop_q      <= 1'b0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            owner_q     <= owner_d;
            drop_q      <= drop_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } dm_op_t;

    logic clk;
    logic rst;
    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macro: data appears MEM_LAT cycles after mem_en is sampled
    logic [15:0] mpipe [MEM_LAT];
    always @(posedge clk) begin
        mpipe[0] <= bus.mem_en ? (bus.mem_addr ^ 16'hA5A5) : 16'hDEAD;
        for (int i = 1; i < MEM_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mem_rdata = mpipe[MEM_LAT-1];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit chk_en = 0;

    // Model: access age 0 = idle, 1 = issue, MEM_LAT+1 = data, MEM_LAT+2 = ready
    int          m_age = 0;
    bit          m_own = 0;
    logic        m_we = 0;
    logic [15:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_dm_rdata = 0;
    logic        m_drop = 0, m_mem_en = 0, m_if_ready = 0, m_dm_ready = 0;
    int          m_starve = 0;

    // Stimulus state
    logic [15:0] if_q[$];
    dm_op_t      dm_q[$];
    bit          rnd_mode = 0, kill_armed = 0, rst_armed = 0;
    logic [15:0] kill_addr = 0;
    int          rst_cnt = 2;
    int          last_if_start = 0, last_dm_start = 0;
    logic        ifr = 0, dmr = 0;

    int          if_log_cyc[$], dm_log_cyc[$], mem_log_cyc[$];
    logic [15:0] if_log_dat[$], dm_log_dat[$], mem_log_addr[$];
    logic        mem_log_we[$];

    function automatic void check(input string name, input logic [15:0] got,
                                  input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    endfunction

    task automatic model_step();
        int a_next;
        bit kill;
        if (!rst) begin
            m_age = 0; m_own = 0; m_we = 0; m_addr = 0; m_wdata = 0;
            m_if_rdata = 0; m_dm_rdata = 0; m_drop = 0; m_starve = 0;
            m_mem_en = 0; m_if_ready = 0; m_dm_ready = 0;
            return;
        end
        m_if_ready = 0;
        m_dm_ready = 0;
        a_next = 0;
        if (m_age == 0) begin
            if (bus.if_req && !bus.flush && (!bus.dm_req || m_starve == STARVE_MAX)) begin
                m_own = 0; m_we = 0; m_addr = bus.if_addr; m_wdata = 0;
                m_starve = 0;
                a_next = 1;
            end else if (bus.dm_req) begin
                m_own = 1; m_we = bus.dm_we; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
                m_starve = bus.if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : 0;
                a_next = 1;
            end
        end else if (m_age == MEM_LAT + 2) begin
            m_drop = 0;
        end else begin
            a_next = m_age + 1;
            if (m_age == MEM_LAT + 1) begin
                kill = m_drop || bus.flush;
                if (m_own == 0 && !kill) begin
                    m_if_ready = 1;
                    m_if_rdata = m_addr ^ 16'hA5A5;
                end
                if (m_own == 1) begin
                    m_dm_ready = 1;
                    if (!m_we) m_dm_rdata = m_addr ^ 16'hA5A5;
                end
            end
            if (m_own == 0 && bus.flush) m_drop = 1;
        end
        if (!bus.if_req) m_starve = 0;
        m_mem_en = (a_next == 1);
        m_age = a_next;
    endtask

    task automatic drive();
        dm_op_t op;
        bus.flush = 0;
        if (rst_armed && m_age == 2) begin
            rst = 0;
            rst_armed = 0;
        end else if (rst_cnt > 0) begin
            rst = 0;
            rst_cnt--;
        end else begin
            rst = 1;
        end
        if (!rst) begin
            bus.if_req = 0;
            bus.dm_req = 0;
            return;
        end
        if (bus.if_req && ifr) bus.if_req = 0;
        if (bus.dm_req && dmr) bus.dm_req = 0;
        // Redirect: kill the fetch in flight and fetch from a new PC
        if (kill_armed && m_age == 2 && m_own == 0 && m_addr == kill_addr) begin
            bus.flush = 1;
            bus.if_addr = bus.if_addr + 16'h0100;
            kill_armed = 0;
        end else if (rnd_mode && $urandom_range(15) == 0) begin
            bus.flush = 1;
            if (bus.if_req) bus.if_addr = 16'($urandom);
        end
        if (!bus.if_req) begin
            if (if_q.size() > 0) begin
                bus.if_addr = if_q.pop_front();
                bus.if_req = 1;
                last_if_start = cyc;
            end else if (rnd_mode && $urandom_range(1) == 1) begin
                bus.if_addr = 16'($urandom);
                bus.if_req = 1;
            end
        end
        if (!bus.dm_req) begin
            if (dm_q.size() > 0) begin
                op = dm_q.pop_front();
                bus.dm_we = op.we; bus.dm_addr = op.addr; bus.dm_wdata = op.wdata;
                bus.dm_req = 1;
                last_dm_start = cyc;
            end else if (rnd_mode && $urandom_range(2) == 0) begin
                bus.dm_we = 1'($urandom_range(1));
                bus.dm_addr = 16'($urandom);
                bus.dm_wdata = 16'($urandom);
                bus.dm_req = 1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.if_ready === 1'b1) begin
                if_log_cyc.push_back(cyc); if_log_dat.push_back(bus.if_rdata);
            end
            if (bus.dm_ready === 1'b1) begin
                dm_log_cyc.push_back(cyc); dm_log_dat.push_back(bus.dm_rdata);
            end
            if (bus.mem_en === 1'b1) begin
                mem_log_cyc.push_back(cyc); mem_log_addr.push_back(bus.mem_addr);
                mem_log_we.push_back(bus.mem_we);
            end
            ifr = m_if_ready;
            dmr = m_dm_ready;
            @(posedge clk);
            model_step();
            cyc++;
            chk_en = 1;
            #1;
            drive();
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_en", 16'(bus.mem_en), 16'(m_mem_en));
            if (m_mem_en) begin
                check("mem_addr", bus.mem_addr, m_addr);
                check("mem_we", 16'(bus.mem_we), 16'(m_we));
                if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
            end
            check("if_ready", 16'(bus.if_ready), 16'(m_if_ready));
            check("dm_ready", 16'(bus.dm_ready), 16'(m_dm_ready));
            check("if_rdata", bus.if_rdata, m_if_rdata);
            check("dm_rdata", bus.dm_rdata, m_dm_rdata);
            check("stall", 16'(bus.stall),
                  16'((bus.if_req & ~m_if_ready) | (bus.dm_req & ~m_dm_ready)));
        end
    end

    initial begin
        int s_if, s_dm, s_mem, hits;
        logic [4:0] we_pat;
        rst = 0;
        bus.if_req = 0; bus.if_addr = 0; bus.flush = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;

        // Reset values
        run(2);
        check("rst_mem_en", 16'(bus.mem_en), 16'h0);
        check("rst_mem_addr", bus.mem_addr, 16'h0);
        check("rst_mem_wdata", bus.mem_wdata, 16'h0);
        check("rst_if_rdata", bus.if_rdata, 16'h0);
        check("rst_dm_rdata", bus.dm_rdata, 16'h0);
        run(2);

        // Single fetch: mem_en at T+1, if_ready at T+4
        if_q.push_back(16'h0010);
        run(8);
        check("t1_mem_en_count", 16'(mem_log_cyc.size()), 16'd1);
        check("t1_if_count", 16'(if_log_cyc.size()), 16'd1);
        if (mem_log_cyc.size() > 0)
            check("t1_mem_en_cyc", 16'(mem_log_cyc[0] - last_if_start), 16'd1);
        if (if_log_cyc.size() > 0) begin
            check("t1_ready_cyc", 16'(if_log_cyc[0] - last_if_start), 16'd4);
            check("t1_if_rdata", if_log_dat[0], 16'hA5B5);
        end
        check("t1_model_rdata", m_if_rdata, 16'hA5B5);

        // Simultaneous IF + DM: DM wins, IF follows
        s_if = if_log_cyc.size(); s_dm = dm_log_cyc.size();
        dm_q.push_back('{we: 1'b0, addr: 16'h0020, wdata: 16'h0000});
        if_q.push_back(16'h0040);
        run(14);
        check("t2_dm_count", 16'(dm_log_cyc.size() - s_dm), 16'd1);
        check("t2_if_count", 16'(if_log_cyc.size() - s_if), 16'd1);
        if (dm_log_cyc.size() > s_dm) begin
            check("t2_dm_rdata", dm_log_dat[s_dm], 16'hA585);
            check("t2_dm_cyc", 16'(dm_log_cyc[s_dm] - last_dm_start), 16'd4);
        end
        if (if_log_cyc.size() > s_if) begin
            check("t2_if_rdata", if_log_dat[s_if], 16'hA5E5);
            check("t2_if_cyc", 16'(if_log_cyc[s_if] - last_if_start), 16'd9);
        end

        // Four back-to-back stores with a pending fetch: IF forced after three
        s_mem = mem_log_cyc.size();
        for (int i = 0; i < 4; i++)
            dm_q.push_back('{we: 1'b1, addr: 16'(16'h0100 + i), wdata: 16'(16'h1000 + i)});
        if_q.push_back(16'h0050);
        run(30);
        we_pat = 5'b10111;
        check("t3_issue_count", 16'(mem_log_cyc.size() - s_mem), 16'd5);
        if (mem_log_cyc.size() >= s_mem + 5) begin
            for (int i = 0; i < 5; i++) check("t3_we_order", 16'(mem_log_we[s_mem+i]), 16'(we_pat[i]));
            check("t3_if_addr", mem_log_addr[s_mem+3], 16'h0050);
        end

        // Flush during WAIT of fetch 0x0030: no ready for it, redirect to 0x0130
        s_mem = mem_log_cyc.size(); s_if = if_log_cyc.size();
        kill_addr = 16'h0030;
        kill_armed = 1;
        if_q.push_back(16'h0030);
        run(14);
        hits = 0;
        for (int i = s_mem; i < mem_log_cyc.size(); i++) if (mem_log_addr[i] == 16'h0030) hits++;
        check("t4_killed_issues", 16'(hits), 16'd1);
        check("t4_if_count", 16'(if_log_cyc.size() - s_if), 16'd1);
        if (if_log_cyc.size() > s_if) check("t4_redirect_rdata", if_log_dat[s_if], 16'hA495);

        // Reset during WAIT of a load: no stale ready, registers cleared
        s_dm = dm_log_cyc.size(); s_mem = mem_log_cyc.size();
        rst_armed = 1;
        dm_q.push_back('{we: 1'b0, addr: 16'h0060, wdata: 16'h0000});
        run(10);
        check("t5_no_ready", 16'(dm_log_cyc.size() - s_dm), 16'd0);
        check("t5_issue_count", 16'(mem_log_cyc.size() - s_mem), 16'd1);
        check("t5_dm_rdata", bus.dm_rdata, 16'h0000);
        check("t5_mem_addr", bus.mem_addr, 16'h0000);

        // Randomized traffic with random flushes
        rnd_mode = 1;
        run(3000);
        rnd_mode = 0;
        run(30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
